partition_scheduler: RTL and testbench
======================================

Name: partition_scheduler

Overview:
- Time-slice scheduler that shares the single 2048-word instruction memory between the operating system (partition 0, words 0-511) and three user programs (partitions 1-3, words 512-2047).
- Sits between the CPU fetch stage and instruction memory.
- Translates the CPU's logical PC into a physical memory address.
- Preempts user programs on quantum expiry, syscall or halt, and hands control back to the OS.
- Saves and restores per-program PCs.

Parameters:
DATA_WIDTH, 32, width of PC, address and resume_pc.
PART_WIDTH, 9, log2 of partition size in words (512).
QCOUNT_WIDTH, 16, width of the quantum counter.
OS_ENTRY, 0, logical PC where the OS resumes after any return from user mode.

Ports:
clock  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-low reset.
pc  input  DATA_WIDTH  logical PC from fetch stage.
step  input  1  CPU retired one instruction this cycle.
os_dispatch  input  1  OS requests dispatch of a user program (sampled in OS state only).
os_target  input  2  1-3 = explicit program; 0 = round-robin next ready.
prog_valid  input  3  bit i-1 set = program i loaded.
prog_halt  input  1  running user program executed halt.
syscall  input  1  running user program trapped to OS; pc holds the return address.
quantum  input  QCOUNT_WIDTH  slice length in retired instructions; 0 = no preemption.
address  output  DATA_WIDTH  physical address, zero-extended {partition, pc[PART_WIDTH-1:0]}; combinational.
partition  output  2  currently selected partition.
user_mode  output  1  high in USER state.
switch_pulse  output  1  one-cycle strobe; the CPU loads resume_pc as its PC.
resume_pc  output  DATA_WIDTH  PC to load on switch_pulse.
cause  output  3  reason for last return to OS: 0 none, 1 quantum, 2 syscall, 3 halt, 4 fault.
dispatch_fail  output  1  one-cycle strobe; dispatch request rejected.
prog_finished  output  3  sticky per-program finished flags.

Behaviour:
- Reset (reset low at a clock edge, any state, including mid-switch):
  - state=OS, partition=0, user_mode=0, switch_pulse=0, dispatch_fail=0.
  - resume_pc=OS_ENTRY, cause=0, prog_finished=0.
  - All three saved PCs=0; counter=0; last_user=3, so the first round-robin pick is program 1.
- address = partition*2^PART_WIDTH + pc[PART_WIDTH-1:0]. Logical PC bits above PART_WIDTH are ignored, so the PC wraps inside its partition.
- A program is eligible when prog_valid[i-1]=1 and prog_finished[i-1]=0.
- OS state, os_dispatch=1:
  - Explicit target: selected if eligible.
  - os_target=0: search last_user+1, +2, +3 (wrapping 3->1); the first eligible program is selected.
  - A selection moves to DISPATCH. No selection gives a dispatch_fail pulse next cycle; state stays OS.
- DISPATCH (1 cycle):
  - partition=target, resume_pc=saved_pc[target], switch_pulse=1.
  - counter loaded with quantum; last_user=target; next state USER.
  - Latency: os_dispatch edge to switch_pulse = 1 cycle.
- USER: on step=1 with counter>1, decrement counter. Exit events, priority high to low:
  - prog_halt: prog_finished[cur]=1, cause=3.
  - syscall: saved_pc[cur]=pc, cause=2.
  - step=1 with counter==1 and quantum-at-dispatch nonzero: saved_pc[cur]=pc, cause=1.
  - Any exit moves to RETURN.
- RETURN (1 cycle): partition=0, user_mode=0, resume_pc=OS_ENTRY, switch_pulse=1; next state OS.
- Signal behaviour by state:
  - os_dispatch is ignored outside OS.
  - prog_halt, syscall and step are ignored outside USER.
  - partition changes in the same cycle switch_pulse asserts.
- quantum=1: preempt after the first retired instruction.
- Halted programs stay ineligible until reset.
- Deasserting prog_valid for the running program does not preempt it.

Optional Feature:
- Macro PART_PROTECT_EN.
- When defined: in USER, any nonzero pc bit above PART_WIDTH is a fault, with lower priority than halt and higher than syscall. The program is marked finished, cause=4 and state goes to RETURN.
- When undefined: high bits are ignored and cause never equals 4.

Test Plan:
- Reset then os_dispatch, os_target=0, prog_valid=3'b111, quantum=3 -> switch_pulse next cycle, partition=1, resume_pc=0; 3 steps with pc=0,1,2 -> RETURN with cause=1, saved_pc[1]=2, address for pc=5 in USER = 517.
- Three consecutive round-robin dispatches with all valid -> partitions 1,2,3, then 1 again resuming at its saved PC.
- prog_halt and syscall in the same USER cycle -> cause=3, prog_finished=3'b001; a later os_target=1 -> dispatch_fail pulse, state stays OS.
- prog_valid=3'b000 with os_dispatch -> dispatch_fail=1 for one cycle, partition stays 0; quantum=0 with 1000 steps -> never preempted.
- reset low in the DISPATCH cycle -> next cycle partition=0, switch_pulse=0, prog_finished=0, saved PCs=0.
- With PART_PROTECT_EN: pc=0x200 in USER on partition 2 -> cause=4, prog_finished[1]=1; without the macro -> address=0x400, no exit.

Source files
------------

// File: rtl/partition_scheduler.sv
// partition_scheduler: time-slice scheduler sharing one 2048-word instruction memory between the OS and three user programs.
// Optional feature macro: PART_PROTECT_EN (pc bits above the partition window fault the running program).
module partition_scheduler #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    PART_WIDTH   = 9,
  parameter int                    QCOUNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] OS_ENTRY     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   pc,
  input  logic                    step,
  input  logic                    os_dispatch,
  input  logic [1:0]              os_target,
  input  logic [2:0]              prog_valid,
  input  logic                    prog_halt,
  input  logic                    syscall,
  input  logic [QCOUNT_WIDTH-1:0] quantum,
  output logic [DATA_WIDTH-1:0]   address,
  output logic [1:0]              partition,
  output logic                    user_mode,
  output logic                    switch_pulse,
  output logic [DATA_WIDTH-1:0]   resume_pc,
  output logic [2:0]              cause,
  output logic                    dispatch_fail,
  output logic [2:0]              prog_finished,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    S_OS       = 2'd0,
    S_DISPATCH = 2'd1,
    S_USER     = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_QUANTUM = 3'd1;
  localparam logic [2:0] C_SYSCALL = 3'd2;
  localparam logic [2:0] C_HALT    = 3'd3;
  localparam logic [2:0] C_FAULT   = 3'd4;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]   saved_pc [0:3];
  logic [QCOUNT_WIDTH-1:0] counter;
  logic                    quantum_nz;
  logic [1:0]              last_user;
  logic [1:0]              target;

  logic [3:0] eligible;
  logic [1:0] cand1, cand2, cand3;
  logic [1:0] sel;
  logic       sel_ok;

  logic       fault_ev;
  logic       q_ev;
  logic       exit_ev;
  logic       save_ev;
  logic       finish_ev;
  logic [2:0] exit_cause;
  logic [2:0] fin_mask;

`ifdef PART_PROTECT_EN
  assign fault_ev = |pc[DATA_WIDTH-1:PART_WIDTH];
`else
  logic unused_pc_hi;
  assign fault_ev     = 1'b0;
  assign unused_pc_hi = ^pc[DATA_WIDTH-1:PART_WIDTH];
`endif

  // Program selection: explicit target, or round-robin starting after the last dispatched program.
  always_comb begin
    eligible = {prog_valid & ~prog_finished, 1'b0};
    cand1    = 2'd1;
    cand2    = 2'd2;
    cand3    = 2'd3;
    case (last_user)
      2'd1:    begin cand1 = 2'd2; cand2 = 2'd3; cand3 = 2'd1; end
      2'd2:    begin cand1 = 2'd3; cand2 = 2'd1; cand3 = 2'd2; end
      default: begin cand1 = 2'd1; cand2 = 2'd2; cand3 = 2'd3; end
    endcase
    sel    = 2'd0;
    sel_ok = 1'b0;
    if (os_target != 2'd0) begin
      sel    = os_target;
      sel_ok = eligible[os_target];
    end else if (eligible[cand1]) begin
      sel    = cand1;
      sel_ok = 1'b1;
    end else if (eligible[cand2]) begin
      sel    = cand2;
      sel_ok = 1'b1;
    end else if (eligible[cand3]) begin
      sel    = cand3;
      sel_ok = 1'b1;
    end
  end

  // Exit events from USER, highest priority first: halt, fault, syscall, quantum expiry.
  always_comb begin
    q_ev       = step && (counter == QCOUNT_WIDTH'(1)) && quantum_nz;
    exit_ev    = 1'b0;
    save_ev    = 1'b0;
    finish_ev  = 1'b0;
    exit_cause = C_NONE;
    if (state == S_USER) begin
      if (prog_halt) begin
        exit_ev    = 1'b1;
        finish_ev  = 1'b1;
        exit_cause = C_HALT;
      end else if (fault_ev) begin
        exit_ev    = 1'b1;
        finish_ev  = 1'b1;
        exit_cause = C_FAULT;
      end else if (syscall) begin
        exit_ev    = 1'b1;
        save_ev    = 1'b1;
        exit_cause = C_SYSCALL;
      end else if (q_ev) begin
        exit_ev    = 1'b1;
        save_ev    = 1'b1;
        exit_cause = C_QUANTUM;
      end
    end
    fin_mask = 3'b000;
    if (finish_ev) begin
      fin_mask = 3'b001 << (target - 2'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_OS;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_OS:       if (os_dispatch && sel_ok) state_next = S_DISPATCH;
      S_DISPATCH: state_next = S_USER;
      S_USER:     if (exit_ev) state_next = S_RETURN;
      S_RETURN:   state_next = S_OS;
      default:    state_next = S_OS;
    endcase
  end

  // switch_pulse is high for exactly the DISPATCH and RETURN cycles; the CPU loads resume_pc
  // as its PC in that cycle, and partition already shows the new owner of the fetch path.
  always_comb begin
    user_mode    = (state == S_USER);
    switch_pulse = (state == S_DISPATCH) || (state == S_RETURN);
    state_dbg    = state;
    address      = '0;
    address[PART_WIDTH+1:0] = {partition, pc[PART_WIDTH-1:0]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      partition     <= 2'd0;
      resume_pc     <= OS_ENTRY;
      cause         <= C_NONE;
      dispatch_fail <= 1'b0;
      prog_finished <= 3'b000;
      for (int i = 0; i < 4; i++) begin
        saved_pc[i] <= '0;
      end
      counter    <= '0;
      quantum_nz <= 1'b0;
      last_user  <= 2'd3;
      target     <= 2'd0;
    end else begin
      dispatch_fail <= 1'b0;
      case (state)
        S_OS: begin
          if (os_dispatch) begin
            if (sel_ok) begin
              target    <= sel;
              partition <= sel;
              resume_pc <= saved_pc[sel];
            end else begin
              dispatch_fail <= 1'b1;
            end
          end
        end
        S_DISPATCH: begin
          counter    <= quantum;
          quantum_nz <= |quantum;
          last_user  <= target;
        end
        S_USER: begin
          if (exit_ev) begin
            partition     <= 2'd0;
            resume_pc     <= OS_ENTRY;
            cause         <= exit_cause;
            prog_finished <= prog_finished | fin_mask;
            if (save_ev) begin
              saved_pc[target] <= pc;
            end
          end else if (step && (counter > QCOUNT_WIDTH'(1))) begin
            counter <= counter - QCOUNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_partition_scheduler.sv
// tb_partition_scheduler: directed scenarios plus randomized traffic checked against a behavioural scheduler model.
module tb_partition_scheduler;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        step;
  logic        os_dispatch;
  logic [1:0]  os_target;
  logic [2:0]  prog_valid;
  logic        prog_halt;
  logic        syscall;
  logic [15:0] quantum;
  logic [31:0] address;
  logic [1:0]  partition;
  logic        user_mode;
  logic        switch_pulse;
  logic [31:0] resume_pc;
  logic [2:0]  cause;
  logic        dispatch_fail;
  logic [2:0]  prog_finished;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  partition_scheduler dut (
    .clock(clock), .reset(reset), .pc(pc), .step(step), .os_dispatch(os_dispatch),
    .os_target(os_target), .prog_valid(prog_valid), .prog_halt(prog_halt), .syscall(syscall),
    .quantum(quantum), .address(address), .partition(partition), .user_mode(user_mode),
    .switch_pulse(switch_pulse), .resume_pc(resume_pc), .cause(cause),
    .dispatch_fail(dispatch_fail), .prog_finished(prog_finished), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural model: mode 0 OS, 1 dispatching, 2 running user, 3 returning
  int          m_mode, m_part, m_cur, m_last, m_cause, m_retired, m_q;
  logic [31:0] m_resume;
  logic [31:0] m_saved [1:3];
  logic [2:0]  m_fin;
  logic        m_fail;

  task automatic model_reset();
    m_mode = 0; m_part = 0; m_cur = 0; m_last = 3; m_cause = 0;
    m_retired = 0; m_q = 0; m_resume = 32'd0; m_fin = 3'b000; m_fail = 1'b0;
    for (int i = 1; i <= 3; i++) m_saved[i] = 32'd0;
  endtask

  function automatic bit elig(int i);
    return prog_valid[i-1] && !m_fin[i-1];
  endfunction

  task automatic model_exit(int c);
    m_cause = c; m_mode = 3; m_part = 0; m_resume = 32'd0;
  endtask

  task automatic model_edge();
    int t;
    m_fail = 1'b0;
    case (m_mode)
      0: if (os_dispatch) begin
           t = 0;
           if (os_target != 0) begin
             if (elig(int'(os_target))) t = int'(os_target);
           end else begin
             for (int k = 1; k <= 3; k++) begin
               int c;
               c = (m_last + k - 1) % 3 + 1;
               if (t == 0 && elig(c)) t = c;
             end
           end
           if (t != 0) begin
             m_cur = t; m_last = t; m_part = t; m_resume = m_saved[t]; m_mode = 1;
           end else begin
             m_fail = 1'b1;
           end
         end
      1: begin m_q = int'(quantum); m_retired = 0; m_mode = 2; end
      2: begin
           if (prog_halt) begin
             m_fin[m_cur-1] = 1'b1; model_exit(3);
           end
`ifdef PART_PROTECT_EN
           else if ((pc >> 9) != 0) begin
             m_fin[m_cur-1] = 1'b1; model_exit(4);
           end
`endif
           else if (syscall) begin
             m_saved[m_cur] = pc; model_exit(2);
           end else if (step) begin
             m_retired++;
             if (m_q != 0 && m_retired == m_q) begin
               m_saved[m_cur] = pc; model_exit(1);
             end
           end
         end
      default: m_mode = 0;
    endcase
  endtask

  // driver tasks
  task automatic clk_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    os_dispatch = 1'b0; os_target = 2'd0; step = 1'b0; prog_halt = 1'b0; syscall = 1'b0; pc = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    clk_edge();
    clk_edge();
    reset = 1'b1;
  endtask

  task automatic dispatch(input logic [1:0] t);
    os_target = t; os_dispatch = 1'b1;
    clk_edge();
    os_dispatch = 1'b0; os_target = 2'd0;
  endtask

  task automatic test_reset();
    prog_valid = 3'b111; quantum = 16'd2;
    do_reset();
    n_cmp++; if (partition !== 2'd0) begin n_err++; $display("FAIL reset_partition got %0d want 0", partition); end
    n_cmp++; if (user_mode !== 1'b0) begin n_err++; $display("FAIL reset_user_mode got %0b want 0", user_mode); end
    n_cmp++; if (switch_pulse !== 1'b0) begin n_err++; $display("FAIL reset_switch got %0b want 0", switch_pulse); end
    n_cmp++; if (resume_pc !== 32'd0) begin n_err++; $display("FAIL reset_resume got %0h want 0", resume_pc); end
    n_cmp++; if (cause !== 3'd0) begin n_err++; $display("FAIL reset_cause got %0d want 0", cause); end
    n_cmp++; if (dispatch_fail !== 1'b0) begin n_err++; $display("FAIL reset_fail got %0b want 0", dispatch_fail); end
    n_cmp++; if (prog_finished !== 3'b000) begin n_err++; $display("FAIL reset_finished got %b want 000", prog_finished); end
  endtask

  task automatic test_quantum_basic();
    do_reset();
    prog_valid = 3'b111; quantum = 16'd3;
    dispatch(2'd0);
    n_cmp++; if (switch_pulse !== 1'b1) begin n_err++; $display("FAIL q_disp_switch got %0b want 1", switch_pulse); end
    n_cmp++; if (partition !== 2'd1) begin n_err++; $display("FAIL q_disp_part got %0d want 1", partition); end
    n_cmp++; if (resume_pc !== 32'd0) begin n_err++; $display("FAIL q_disp_resume got %0h want 0", resume_pc); end
    clk_edge();
    n_cmp++; if (user_mode !== 1'b1) begin n_err++; $display("FAIL q_user got %0b want 1", user_mode); end
    pc = 32'd5;
    #1;
    n_cmp++; if (address !== 32'd517) begin n_err++; $display("FAIL q_address got %0d want 517", address); end
    for (int i = 0; i < 3; i++) begin
      pc = i; step = 1'b1;
      clk_edge();
      if (i < 2) begin
        n_cmp++; if (user_mode !== 1'b1) begin n_err++; $display("FAIL q_still_user step %0d got %0b want 1", i, user_mode); end
      end
    end
    step = 1'b0;
    n_cmp++; if (switch_pulse !== 1'b1) begin n_err++; $display("FAIL q_ret_switch got %0b want 1", switch_pulse); end
    n_cmp++; if (partition !== 2'd0) begin n_err++; $display("FAIL q_ret_part got %0d want 0", partition); end
    n_cmp++; if (cause !== 3'd1) begin n_err++; $display("FAIL q_ret_cause got %0d want 1", cause); end
    clk_edge();
    n_cmp++; if (switch_pulse !== 1'b0) begin n_err++; $display("FAIL q_os_switch got %0b want 0", switch_pulse); end
    dispatch(2'd1);
    n_cmp++; if (resume_pc !== 32'd2) begin n_err++; $display("FAIL q_saved_pc got %0h want 2", resume_pc); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_q[$];
    logic [1:0] exp_p;
    logic [31:0] exp_r;
    do_reset();
    prog_valid = 3'b111; quantum = 16'd1;
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd1};
    for (int r = 0; r < 4; r++) begin
      exp_p = exp_q.pop_front();
      exp_r = (r == 3) ? 32'd23 : 32'd0;
      dispatch(2'd0);
      n_cmp++; if (partition !== exp_p) begin n_err++; $display("FAIL rr_part round %0d got %0d want %0d", r, partition, exp_p); end
      n_cmp++; if (resume_pc !== exp_r) begin n_err++; $display("FAIL rr_resume round %0d got %0h want %0h", r, resume_pc, exp_r); end
      clk_edge();
      pc = 32'd16 * exp_p + 32'd7; step = 1'b1;
      clk_edge();
      step = 1'b0;
      n_cmp++; if (cause !== 3'd1) begin n_err++; $display("FAIL rr_cause round %0d got %0d want 1", r, cause); end
      clk_edge();
    end
  endtask

  task automatic test_halt_priority();
    do_reset();
    prog_valid = 3'b111; quantum = 16'd0;
    dispatch(2'd1);
    clk_edge();
    prog_halt = 1'b1; syscall = 1'b1; pc = 32'd9;
    clk_edge();
    prog_halt = 1'b0; syscall = 1'b0;
    n_cmp++; if (cause !== 3'd3) begin n_err++; $display("FAIL halt_cause got %0d want 3", cause); end
    n_cmp++; if (prog_finished !== 3'b001) begin n_err++; $display("FAIL halt_finished got %b want 001", prog_finished); end
    clk_edge();
    dispatch(2'd1);
    n_cmp++; if (dispatch_fail !== 1'b1) begin n_err++; $display("FAIL halt_fail got %0b want 1", dispatch_fail); end
    n_cmp++; if (switch_pulse !== 1'b0) begin n_err++; $display("FAIL halt_no_switch got %0b want 0", switch_pulse); end
    clk_edge();
    n_cmp++; if (dispatch_fail !== 1'b0) begin n_err++; $display("FAIL halt_fail_pulse got %0b want 0", dispatch_fail); end
    dispatch(2'd0);
    n_cmp++; if (partition !== 2'd2) begin n_err++; $display("FAIL halt_rr_skip got %0d want 2", partition); end
  endtask

  task automatic test_no_valid_no_quantum();
    do_reset();
    prog_valid = 3'b000; quantum = 16'd0;
    dispatch(2'd0);
    n_cmp++; if (dispatch_fail !== 1'b1) begin n_err++; $display("FAIL nv_fail got %0b want 1", dispatch_fail); end
    n_cmp++; if (partition !== 2'd0) begin n_err++; $display("FAIL nv_part got %0d want 0", partition); end
    clk_edge();
    n_cmp++; if (dispatch_fail !== 1'b0) begin n_err++; $display("FAIL nv_fail_pulse got %0b want 0", dispatch_fail); end
    prog_valid = 3'b111;
    dispatch(2'd2);
    clk_edge();
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) prog_valid = 3'b000;
      pc = $urandom_range(0, 511); step = 1'b1;
      clk_edge();
      n_cmp++; if (user_mode !== 1'b1) begin n_err++; $display("FAIL nq_preempted step %0d got %0b want 1", i, user_mode); end
    end
    step = 1'b0; syscall = 1'b1; pc = 32'd77;
    clk_edge();
    syscall = 1'b0;
    n_cmp++; if (cause !== 3'd2) begin n_err++; $display("FAIL sys_cause got %0d want 2", cause); end
    clk_edge();
    prog_valid = 3'b111;
    dispatch(2'd2);
    n_cmp++; if (resume_pc !== 32'd77) begin n_err++; $display("FAIL sys_resume got %0h want 4d", resume_pc); end
  endtask

  task automatic test_reset_in_dispatch();
    do_reset();
    prog_valid = 3'b111; quantum = 16'd1;
    dispatch(2'd1);
    clk_edge();
    pc = 32'd33; step = 1'b1;
    clk_edge();
    step = 1'b0;
    clk_edge();
    dispatch(2'd3);
    clk_edge();
    prog_halt = 1'b1;
    clk_edge();
    prog_halt = 1'b0;
    clk_edge();
    n_cmp++; if (prog_finished !== 3'b100) begin n_err++; $display("FAIL rd_pre_finished got %b want 100", prog_finished); end
    dispatch(2'd2);
    reset = 1'b0;
    clk_edge();
    reset = 1'b1;
    n_cmp++; if (partition !== 2'd0) begin n_err++; $display("FAIL rd_part got %0d want 0", partition); end
    n_cmp++; if (switch_pulse !== 1'b0) begin n_err++; $display("FAIL rd_switch got %0b want 0", switch_pulse); end
    n_cmp++; if (prog_finished !== 3'b000) begin n_err++; $display("FAIL rd_finished got %b want 000", prog_finished); end
    n_cmp++; if (user_mode !== 1'b0) begin n_err++; $display("FAIL rd_user got %0b want 0", user_mode); end
    dispatch(2'd0);
    n_cmp++; if (partition !== 2'd1) begin n_err++; $display("FAIL rd_rr_first got %0d want 1", partition); end
    n_cmp++; if (resume_pc !== 32'd0) begin n_err++; $display("FAIL rd_saved_clear got %0h want 0", resume_pc); end
  endtask

  task automatic test_high_pc();
    do_reset();
    prog_valid = 3'b111; quantum = 16'd0;
    dispatch(2'd2);
    clk_edge();
    pc = 32'h200;
    #1;
    n_cmp++; if (address !== 32'h400) begin n_err++; $display("FAIL hi_address got %0h want 400", address); end
    clk_edge();
`ifdef PART_PROTECT_EN
    n_cmp++; if (cause !== 3'd4) begin n_err++; $display("FAIL hi_cause got %0d want 4", cause); end
    n_cmp++; if (prog_finished !== 3'b010) begin n_err++; $display("FAIL hi_finished got %b want 010", prog_finished); end
`else
    n_cmp++; if (user_mode !== 1'b1) begin n_err++; $display("FAIL hi_no_exit got %0b want 1", user_mode); end
    n_cmp++; if (cause !== 3'd0) begin n_err++; $display("FAIL hi_cause got %0d want 0", cause); end
`endif
    pc = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] exp_addr;
    do_reset();
    model_reset();
    prog_valid = 3'b111;
    for (int c = 0; c < 1500; c++) begin
      reset       = ($urandom_range(0, 99) != 0);
      os_dispatch = ($urandom_range(0, 2) == 0);
      os_target   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) prog_valid = 3'($urandom_range(0, 7));
      prog_halt   = ($urandom_range(0, 29) == 0);
      syscall     = ($urandom_range(0, 9) == 0);
      step        = 1'($urandom_range(0, 1));
      quantum     = 16'($urandom_range(0, 4));
      pc          = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511));
      #1;
      exp_addr = 32'(m_part) * 32'd512 + (pc % 32'd512);
      n_cmp++; if (address !== exp_addr) begin n_err++; $display("FAIL rnd_address cyc %0d got %0h want %0h", c, address, exp_addr); end
      if (!reset) model_reset(); else model_edge();
      clk_edge();
      n_cmp++; if (partition !== 2'(m_part)) begin n_err++; $display("FAIL rnd_part cyc %0d got %0d want %0d", c, partition, m_part); end
      n_cmp++; if (user_mode !== (m_mode == 2)) begin n_err++; $display("FAIL rnd_user cyc %0d got %0b want %0b", c, user_mode, m_mode == 2); end
      n_cmp++; if (switch_pulse !== (m_mode == 1 || m_mode == 3)) begin n_err++; $display("FAIL rnd_switch cyc %0d got %0b want %0b", c, switch_pulse, m_mode == 1 || m_mode == 3); end
      n_cmp++; if (resume_pc !== m_resume) begin n_err++; $display("FAIL rnd_resume cyc %0d got %0h want %0h", c, resume_pc, m_resume); end
      n_cmp++; if (cause !== 3'(m_cause)) begin n_err++; $display("FAIL rnd_cause cyc %0d got %0d want %0d", c, cause, m_cause); end
      n_cmp++; if (dispatch_fail !== m_fail) begin n_err++; $display("FAIL rnd_fail cyc %0d got %0b want %0b", c, dispatch_fail, m_fail); end
      n_cmp++; if (prog_finished !== m_fin) begin n_err++; $display("FAIL rnd_finished cyc %0d got %b want %b", c, prog_finished, m_fin); end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; prog_valid = 3'b000; quantum = 16'd0;
    idle_inputs();
    test_reset();
    test_quantum_basic();
    test_round_robin();
    test_halt_priority();
    test_no_valid_no_quantum();
    test_reset_in_dispatch();
    test_high_pc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
